// File: rtl/wshb_arb_pkg.sv
// -----------------------------------------------------------------------------
// wshb_arb_pkg
// Shared types and helpers for the two-master Wishbone arbiter.
//   arb_state_t : owner FSM encoding (IDLE / OWN0 / OWN1)
//   cnt_width() : width of the per-grant ack counter for a given MAX_BURST
// -----------------------------------------------------------------------------
package wshb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // Counter must be able to hold MAX_BURST itself (saturation value for an
    // unlimited owner), hence +1 before the log.
    function automatic int cnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/wshb_if_DATA_BYTES_2_ADDRESS_WIDTH_32.sv
// -----------------------------------------------------------------------------
// wshb_if_DATA_BYTES_2_ADDRESS_WIDTH_32
// Wishbone bus bundle, 16-bit data (2 byte lanes), 32-bit address.
//   master modport : drives cyc/stb/we/adr/dat_ms/sel/cti/bte, receives dat_sm/ack
//   slave  modport : mirror of master
// -----------------------------------------------------------------------------
interface wshb_if_DATA_BYTES_2_ADDRESS_WIDTH_32;

    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [15:0] dat_ms;
    logic [15:0] dat_sm;
    logic [1:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;

    modport master (
        output cyc, stb, we, adr, dat_ms, sel, cti, bte,
        input  dat_sm, ack
    );

    modport slave (
        input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
        output dat_sm, ack
    );

endinterface

// File: rtl/wshb_arb_fsm.sv
// -----------------------------------------------------------------------------
// wshb_arb_fsm
// Owner FSM, per-grant ack counter and last-owner register of the two-master
// Wishbone arbiter.
//
// Ports
//   clk   in   Wishbone clock
//   rst   in   synchronous active-high reset
//   req0  in   master 0 request (cyc & stb)
//   req1  in   master 1 request (cyc & stb)
//   ack   in   slave-side ack
//   state out  current owner
//   last  out  last owner served (1 after reset so master 0 wins first tie)
//   cnt   out  acks collected by the current owner
//
// Build option: WSHB_ARB_FIXED_PRIO_EN -- master 0 wins every tie and is not
// subject to the MAX_BURST limit; master 1 stays limited.
//
// state | meaning
// ------+------------------------------
// IDLE  | no grant, wb_m quiet
// OWN0  | master 0 owns the slave port
// OWN1  | master 1 owns the slave port
// -----------------------------------------------------------------------------
module wshb_arb_fsm
    import wshb_arb_pkg::*;
#(
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = cnt_width(MAX_BURST)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic             ack,
    output arb_state_t       state,
    output logic             last,
    output logic [CNT_W-1:0] cnt
);

`ifdef WSHB_ARB_FIXED_PRIO_EN
    localparam bit FIXED_PRIO = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;
`endif

    // Master 0 escapes the burst limit only in fixed-priority builds.
    localparam bit LIMIT0 = !FIXED_PRIO;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MAX_BURST);

    arb_state_t       state_nxt;
    logic             last_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             at_limit;

    assign at_limit = ack && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last  <= 1'b1;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        cnt_nxt   = cnt;

        unique case (state)
            IDLE: begin
                // A stray ack here is a slave protocol error and is ignored.
                if (req0 && req1) begin
                    state_nxt = (FIXED_PRIO || last) ? OWN0 : OWN1;
                end else if (req0) begin
                    state_nxt = OWN0;
                end else if (req1) begin
                    state_nxt = OWN1;
                end
            end

            OWN0: begin
                if (!req0 || (LIMIT0 && at_limit)) begin
                    // Hand straight over on the releasing edge: no bubble.
                    state_nxt = req1 ? OWN1 : IDLE;
                    last_nxt  = 1'b0;
                    cnt_nxt   = '0;
                end else if (ack && (cnt != CNT_SAT)) begin
                    // Saturate so an unlimited owner cannot wrap the counter.
                    cnt_nxt = cnt + 1'b1;
                end
            end

            OWN1: begin
                if (!req1 || at_limit) begin
                    state_nxt = req0 ? OWN0 : IDLE;
                    last_nxt  = 1'b1;
                    cnt_nxt   = '0;
                end else if (ack && (cnt != CNT_SAT)) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/wshb_arbiter_2m.sv
// -----------------------------------------------------------------------------
// wshb_arbiter_2m
// Two-master Wishbone arbiter sharing the SDRAM-side port between the display
// reader (master 0) and the frame writer (master 1). Grant is registered;
// data and ack paths through an owned grant are purely combinational.
//
// Parameters
//   MAX_BURST  acks per grant before forced release (1..255)
//   ADR_W      forwarded address width, must equal the interface width (32)
//
// Ports
//   CLK    in   Wishbone clock
//   RST    in   synchronous active-high reset
//   wb_s0  slave modport, master 0 (display reader) attaches here
//   wb_s1  slave modport, master 1 (frame writer) attaches here
//   wb_m   master modport, towards the memory controller
//
// Build option: WSHB_ARB_FIXED_PRIO_EN (see wshb_arb_fsm).
// -----------------------------------------------------------------------------
module wshb_arbiter_2m
    import wshb_arb_pkg::*;
#(
    parameter int MAX_BURST = 16,
    parameter int ADR_W     = 32
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    wshb_if_DATA_BYTES_2_ADDRESS_WIDTH_32.slave   wb_s0,
    wshb_if_DATA_BYTES_2_ADDRESS_WIDTH_32.slave   wb_s1,
    wshb_if_DATA_BYTES_2_ADDRESS_WIDTH_32.master  wb_m
);

    localparam int CNT_W = cnt_width(MAX_BURST);

    arb_state_t       state;
    logic             fsm_last;
    logic [CNT_W-1:0] fsm_cnt;
    logic             req0;
    logic             req1;
    logic [ADR_W-1:0] adr_mux;

    // The display master keeps cyc high permanently, so only cyc & stb counts
    // as a request.
    assign req0 = wb_s0.cyc & wb_s0.stb;
    assign req1 = wb_s1.cyc & wb_s1.stb;

    wshb_arb_fsm #(
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) u_fsm (
        .clk   (CLK),
        .rst   (RST),
        .req0  (req0),
        .req1  (req1),
        .ack   (wb_m.ack),
        .state (state),
        .last  (fsm_last),
        .cnt   (fsm_cnt)
    );

    // last/cnt only steer the FSM itself; they are brought out for debug.
    logic unused_fsm_status;
    assign unused_fsm_status = ^{fsm_last, fsm_cnt};

    always_comb begin
        wb_m.cyc    = 1'b0;
        wb_m.stb    = 1'b0;
        wb_m.we     = 1'b0;
        adr_mux     = '0;
        wb_m.dat_ms = '0;
        wb_m.sel    = '0;
        wb_m.cti    = '0;
        wb_m.bte    = '0;
        wb_s0.ack   = 1'b0;
        wb_s1.ack   = 1'b0;

        unique case (state)
            OWN0: begin
                wb_m.cyc    = wb_s0.cyc;
                wb_m.stb    = wb_s0.stb;
                wb_m.we     = wb_s0.we;
                adr_mux     = wb_s0.adr;
                wb_m.dat_ms = wb_s0.dat_ms;
                wb_m.sel    = wb_s0.sel;
                wb_m.cti    = wb_s0.cti;
                wb_m.bte    = wb_s0.bte;
                wb_s0.ack   = wb_m.ack;
            end
            OWN1: begin
                wb_m.cyc    = wb_s1.cyc;
                wb_m.stb    = wb_s1.stb;
                wb_m.we     = wb_s1.we;
                adr_mux     = wb_s1.adr;
                wb_m.dat_ms = wb_s1.dat_ms;
                wb_m.sel    = wb_s1.sel;
                wb_m.cti    = wb_s1.cti;
                wb_m.bte    = wb_s1.bte;
                wb_s1.ack   = wb_m.ack;
            end
            default: begin
                // No owner: bus quiet, any ack from the slave is dropped.
            end
        endcase
    end

    assign wb_m.adr = adr_mux;

    // Read data is harmless to broadcast; only the ack qualifies it.
    assign wb_s0.dat_sm = wb_m.dat_sm;
    assign wb_s1.dat_sm = wb_m.dat_sm;

endmodule

// File: tb/tb_wshb_arbiter_2m.sv
module tb_wshb_arbiter_2m;
    import wshb_arb_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst       = 1'b1;
    logic       clr       = 1'b1;
    logic       cyc0      = 1'b0;
    logic       cyc1      = 1'b0;
    logic       force_ack = 1'b0;
    logic [7:0] tgt0      = 8'd0;
    logic [7:0] tgt1      = 8'd0;
    logic [7:0] done0;
    logic [7:0] done1;

    int          n_eval = 0;
    int          n_fail = 0;
    int          ack0_cnt;
    int          ack1_cnt;
    int          ack_total;
    logic [15:0] ack_log;

    wshb_if_DATA_BYTES_2_ADDRESS_WIDTH_32 s0 ();
    wshb_if_DATA_BYTES_2_ADDRESS_WIDTH_32 s1 ();
    wshb_if_DATA_BYTES_2_ADDRESS_WIDTH_32 m  ();

    // Master models: hold stb until tgt transfers have been acked.
    assign s0.cyc    = cyc0;
    assign s0.stb    = cyc0 && (done0 != tgt0);
    assign s0.we     = 1'b0;
    assign s0.adr    = 32'h0000_1000 + {24'h0, done0};
    assign s0.dat_ms = {8'hA0, done0};
    assign s0.sel    = 2'b11;
    assign s0.cti    = 3'b000;
    assign s0.bte    = 2'b00;

    assign s1.cyc    = cyc1;
    assign s1.stb    = cyc1 && (done1 != tgt1);
    assign s1.we     = 1'b1;
    assign s1.adr    = 32'h0000_2000 + {24'h0, done1};
    assign s1.dat_ms = {8'hB0, done1};
    assign s1.sel    = 2'b01;
    assign s1.cti    = 3'b010;
    assign s1.bte    = 2'b01;

    // Zero-wait slave: acks in the same cycle as the strobe.
    assign m.ack    = force_ack | (m.cyc & m.stb);
    assign m.dat_sm = m.cyc ? 16'hC3A5 : 16'h0000;

    always @(posedge clk) begin
        if (clr) begin
            done0     <= 8'd0;
            done1     <= 8'd0;
            ack0_cnt  <= 0;
            ack1_cnt  <= 0;
            ack_total <= 0;
            ack_log   <= 16'h0;
        end else begin
            if (s0.ack) begin
                done0    <= done0 + 8'd1;
                ack0_cnt <= ack0_cnt + 1;
            end
            if (s1.ack) begin
                done1    <= done1 + 8'd1;
                ack1_cnt <= ack1_cnt + 1;
            end
            if (m.ack) begin
                ack_total <= ack_total + 1;
                ack_log   <= {ack_log[14:0], s1.ack};
            end
        end
    end

    wshb_arbiter_2m #(
        .MAX_BURST (4),
        .ADR_W     (32)
    ) dut (
        .CLK   (clk),
        .RST   (rst),
        .wb_s0 (s0),
        .wb_s1 (s1),
        .wb_m  (m)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_eval++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

`ifdef WSHB_ARB_FIXED_PRIO_EN
    localparam logic [31:0] EXP_HANDOVER_ADR = 32'h0000_1004;
    localparam logic [31:0] EXP_HANDOVER_S1  = 32'd0;
    localparam logic [31:0] EXP_ACK_TOTAL    = 32'd14;
    localparam logic [31:0] EXP_ACK_LOG      = 32'h0000_003F;
    localparam arb_state_t  EXP_END_STATE    = OWN1;
`else
    localparam logic [31:0] EXP_HANDOVER_ADR = 32'h0000_2000;
    localparam logic [31:0] EXP_HANDOVER_S1  = 32'd1;
    localparam logic [31:0] EXP_ACK_TOTAL    = 32'd16;
    localparam logic [31:0] EXP_ACK_LOG      = 32'h0000_0F0F;
    localparam arb_state_t  EXP_END_STATE    = IDLE;
`endif

    initial begin
        // Reset state
        step(3);
        rst = 1'b0;
        clr = 1'b0;
        check("rst_state", 32'(dut.u_fsm.state), 32'(IDLE));
        check("rst_cnt",   32'(dut.u_fsm.cnt),   32'd0);
        check("rst_last",  32'(dut.u_fsm.last),  32'd1);
        check("rst_m_cyc", 32'(m.cyc), 32'd0);
        check("rst_m_stb", 32'(m.stb), 32'd0);
        check("rst_m_adr", m.adr, 32'd0);
        check("rst_m_sel", 32'(m.sel), 32'd0);
        check("rst_s0_ack", 32'(s0.ack), 32'd0);
        check("rst_s1_ack", 32'(s1.ack), 32'd0);

        // Master 1 alone writes 3 words
        cyc1 = 1'b1;
        tgt1 = 8'd3;
        check("t1_no_grant_yet", 32'(m.cyc), 32'd0);
        step(1);
        check("t1_m_cyc",   32'(m.cyc), 32'd1);
        check("t1_m_we",    32'(m.we),  32'd1);
        check("t1_m_adr",   m.adr, 32'h0000_2000);
        check("t1_m_sel",   32'(m.sel), 32'd1);
        check("t1_m_cti",   32'(m.cti), 32'd2);
        check("t1_s1_ack",  32'(s1.ack), 32'd1);
        check("t1_s0_ack",  32'(s0.ack), 32'd0);
        check("t1_dat_sm0", 32'(s0.dat_sm), 32'h0000_C3A5);
        check("t1_dat_sm1", 32'(s1.dat_sm), 32'h0000_C3A5);
        step(5);
        check("t1_acks_s1", 32'(ack1_cnt), 32'd3);
        check("t1_acks_s0", 32'(ack0_cnt), 32'd0);
        check("t1_state",   32'(dut.u_fsm.state), 32'(IDLE));
        check("t1_last",    32'(dut.u_fsm.last),  32'd1);
        check("t1_cnt",     32'(dut.u_fsm.cnt),   32'd0);
        cyc1 = 1'b0;

        // Both masters, 8 transfers each, MAX_BURST = 4
        rst = 1'b1;
        clr = 1'b1;
        step(1);
        rst = 1'b0;
        clr = 1'b0;
        cyc0 = 1'b1;
        cyc1 = 1'b1;
        tgt0 = 8'd8;
        tgt1 = 8'd8;
        step(1);
        check("t2_first_state", 32'(dut.u_fsm.state), 32'(OWN0));
        check("t2_first_adr",   m.adr, 32'h0000_1000);
        check("t2_first_s0ack", 32'(s0.ack), 32'd1);
        check("t2_first_s1ack", 32'(s1.ack), 32'd0);
        step(4);
        check("t2_handover_adr", m.adr, EXP_HANDOVER_ADR);
        check("t2_handover_s1",  32'(s1.ack), EXP_HANDOVER_S1);
        step(12);
        check("t3_ack_total", 32'(ack_total), EXP_ACK_TOTAL);
        check("t3_ack_order", 32'(ack_log), EXP_ACK_LOG);
        check("t3_end_state", 32'(dut.u_fsm.state), 32'(EXP_END_STATE));
        cyc0 = 1'b0;
        cyc1 = 1'b0;

        // Reset while master 1 owns the bus with cnt = 2
        rst = 1'b1;
        clr = 1'b1;
        step(1);
        rst = 1'b0;
        clr = 1'b0;
        cyc1 = 1'b1;
        tgt1 = 8'd8;
        step(1);
        check("t4_own1", 32'(dut.u_fsm.state), 32'(OWN1));
        step(2);
        check("t4_cnt2", 32'(dut.u_fsm.cnt), 32'd2);
        rst  = 1'b1;
        cyc0 = 1'b1;
        tgt0 = 8'd8;
        step(1);
        check("t4_m_cyc",  32'(m.cyc), 32'd0);
        check("t4_m_stb",  32'(m.stb), 32'd0);
        check("t4_cnt",    32'(dut.u_fsm.cnt), 32'd0);
        check("t4_state",  32'(dut.u_fsm.state), 32'(IDLE));
        check("t4_last",   32'(dut.u_fsm.last), 32'd1);
        check("t4_s1_ack", 32'(s1.ack), 32'd0);
        rst = 1'b0;
        step(1);
        check("t4_regrant_state", 32'(dut.u_fsm.state), 32'(OWN0));
        check("t4_regrant_adr",   m.adr, 32'h0000_1000);
        check("t4_regrant_s0ack", 32'(s0.ack), 32'd1);

        // Spurious ack in IDLE
        cyc0 = 1'b0;
        cyc1 = 1'b0;
        step(1);
        check("t5_idle",      32'(dut.u_fsm.state), 32'(IDLE));
        check("t5_last",      32'(dut.u_fsm.last), 32'd0);
        force_ack = 1'b1;
        check("t5_s0_ack",    32'(s0.ack), 32'd0);
        check("t5_s1_ack",    32'(s1.ack), 32'd0);
        check("t5_m_cyc",     32'(m.cyc), 32'd0);
        step(1);
        force_ack = 1'b0;
        check("t5_state_after", 32'(dut.u_fsm.state), 32'(IDLE));
        check("t5_cnt_after",   32'(dut.u_fsm.cnt), 32'd0);
        check("t5_last_after",  32'(dut.u_fsm.last), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end

endmodule
